// File: rtl/d_cache_2way_pkg.sv
// Shared types and helpers for the two-way write-through data cache.
// Line layout: word0 occupies bits [15:0], word3 bits [63:48].
package d_cache_2way_pkg;

  localparam int LINE_WORDS = 4;
  localparam int WORD_W     = 16;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int ADDR_W     = 16;

  typedef enum logic [1:0] {
    DC_IDLE  = 2'd0,
    DC_FETCH = 2'd1,
    DC_WRITE = 2'd2
  } dc_state_e;

  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        off);
    return line[off*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] set_word(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        off,
                                                 input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] res;
    res = line;
    res[off*WORD_W +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/d_cache_2way_way_array.sv
// One cache way: per-set valid bit, tag and 64-bit line, with a combinational
// read port and a write port that can fill a whole line and/or merge one word.
module dcache_way_array
  import d_cache_2way_pkg::*;
#(
  parameter int NUM_SETS = 2,
  parameter int IB       = $clog2(NUM_SETS),
  parameter int TAG_W    = ADDR_W - 2 - IB
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IB-1:0]     idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              merge_en,
  input  logic [1:0]        merge_off,
  input  logic [WORD_W-1:0] merge_data
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];
  logic [LINE_W-1:0]   line_d;

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  // A fill and a merge on the same edge store the fetched line with the word overlaid.
  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[idx] = 1'b1;
    line_d = fill_en ? fill_line : data_q[idx];
    if (merge_en) line_d = set_word(line_d, merge_off, merge_data);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  // NOTE: tag/data storage has no reset; the valid bits alone decide whether contents are meaningful.
  always_ff @(posedge clk) begin
    if (fill_en || merge_en) data_q[idx] <= line_d;
    if (fill_en)             tag_q[idx]  <= fill_tag;
  end

endmodule

// File: rtl/d_cache_2way.sv
// Two-way set-associative, write-through/write-allocate data cache with LRU
// replacement, fixed-latency line transfers and hit/miss statistics.
module d_cache_2way
  import d_cache_2way_pkg::*;
#(
  parameter int NUM_SETS    = 2,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_cache,
  input  logic        write_cache,
  input  logic [15:0] address_cache,
  inout  wire  [15:0] data_cache_datapath,
  inout  wire  [63:0] data_mem_cache,
  output logic        doneRead,
  output logic        doneWrite,
  output logic [15:0] address_memory,
  output logic        readM,
  output logic        writeM,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int IB    = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - 2 - IB;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  dc_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic                way_q, way_d;
  logic                refill_q, refill_d;
  logic [NUM_SETS-1:0] lru_q, lru_d;
  logic [15:0]         hit_count_q, hit_count_d;
  logic [15:0]         miss_count_q, miss_count_d;

  logic [15:0]       cur_addr;
  logic [IB-1:0]     idx;
  logic [TAG_W-1:0]  cur_tag;
  logic [1:0]        rd_valid, hit_w, fill_en, merge_en;
  logic [TAG_W-1:0]  rd_tag  [2];
  logic [LINE_W-1:0] rd_line [2];
  logic              hit, hit_way, victim;
  logic [WORD_W-1:0] merge_data;

  // Outside IDLE every lookup refers to the latched request, not the live bus.
  assign cur_addr   = (state_q == DC_IDLE) ? address_cache : addr_q;
  assign idx        = cur_addr[2 +: IB];
  assign cur_tag    = cur_addr[15 -: TAG_W];
  assign merge_data = (state_q == DC_IDLE) ? data_cache_datapath : wdata_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign hit_w[w] = rd_valid[w] && (rd_tag[w] == cur_tag);
    dcache_way_array #(.NUM_SETS(NUM_SETS), .IB(IB), .TAG_W(TAG_W)) u_way (
      .clk        (clk),
      .reset_n    (reset_n),
      .idx        (idx),
      .rd_valid   (rd_valid[w]),
      .rd_tag     (rd_tag[w]),
      .rd_line    (rd_line[w]),
      .fill_en    (fill_en[w]),
      .fill_tag   (cur_tag),
      .fill_line  (data_mem_cache),
      .merge_en   (merge_en[w]),
      .merge_off  (cur_addr[1:0]),
      .merge_data (merge_data)
    );
  end

  assign hit     = |hit_w;
  assign hit_way = hit_w[1];
  assign victim  = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : lru_q[idx]);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_wr_d      = is_wr_q;
    way_d        = way_q;
    refill_d     = refill_q;
    lru_d        = lru_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    fill_en      = '0;
    merge_en     = '0;
    unique case (state_q)
      DC_IDLE: begin
        refill_d = 1'b0;
        cnt_d    = '0;
        if (write_cache) begin
          addr_d       = address_cache;
          wdata_d      = data_cache_datapath;
          is_wr_d      = 1'b1;
          if (hit) begin
            merge_en[hit_way] = 1'b1;
            way_d             = hit_way;
            lru_d[idx]        = ~hit_way;
            hit_count_d       = hit_count_q + 16'd1;
            state_d           = DC_WRITE;
          end else begin
            way_d        = victim;
            miss_count_d = miss_count_q + 16'd1;
            state_d      = DC_FETCH;
          end
        end else if (read_cache) begin
          if (hit) begin
            lru_d[idx] = ~hit_way;
            // The retry right after a refill is the same access, already counted as a miss.
            if (!refill_q) hit_count_d = hit_count_q + 16'd1;
          end else begin
            addr_d       = address_cache;
            is_wr_d      = 1'b0;
            way_d        = victim;
            miss_count_d = miss_count_q + 16'd1;
            state_d      = DC_FETCH;
          end
        end
      end
      DC_FETCH: begin
        if (cnt_q == CNT_LAST) begin
          fill_en[way_q]  = 1'b1;
          merge_en[way_q] = is_wr_q;
          lru_d[idx]      = ~way_q;
          cnt_d           = '0;
          refill_d        = !is_wr_q;
          state_d         = is_wr_q ? DC_WRITE : DC_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DC_WRITE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DC_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DC_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DC_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_wr_q      <= 1'b0;
      way_q        <= 1'b0;
      refill_q     <= 1'b0;
      lru_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_wr_q      <= is_wr_d;
      way_q        <= way_d;
      refill_q     <= refill_d;
      lru_q        <= lru_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign readM          = (state_q == DC_FETCH);
  assign writeM         = (state_q == DC_WRITE);
  assign doneWrite      = writeM && (cnt_q == CNT_LAST);
  assign doneRead       = (state_q == DC_IDLE) && read_cache && !write_cache && hit;
  assign address_memory = {addr_q[15:2], 2'b00};
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;

  assign data_cache_datapath = doneRead ? get_word(rd_line[hit_way], cur_addr[1:0]) : 16'hzzzz;
  assign data_mem_cache      = writeM ? rd_line[way_q] : {LINE_W{1'bz}};

endmodule

// File: tb/tb_d_cache_2way.sv
// Directed bench for d_cache_2way: a line-memory model answers readM, and each
// access is checked for data, strobe lengths, line address and statistics.
module tb_d_cache_2way;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_cache, write_cache;
  logic [15:0] address_cache;
  logic [15:0] wdrv;
  wire  [15:0] dbus;
  wire  [63:0] mbus;
  logic        doneRead, doneWrite, readM, writeM;
  logic [15:0] address_memory, hit_count, miss_count;

  logic [63:0] mem [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign dbus = write_cache ? wdrv : 16'hzzzz;
  assign mbus = readM ? mem[address_memory[9:2]] : 64'hzzzz_zzzz_zzzz_zzzz;

  d_cache_2way #(.NUM_SETS(2), .MEM_LATENCY(4)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .read_cache          (read_cache),
    .write_cache         (write_cache),
    .address_cache       (address_cache),
    .data_cache_datapath (dbus),
    .data_mem_cache      (mbus),
    .doneRead            (doneRead),
    .doneWrite           (doneWrite),
    .address_memory      (address_memory),
    .readM               (readM),
    .writeM              (writeM),
    .hit_count           (hit_count),
    .miss_count          (miss_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag, input int exp_hit, input int exp_miss);
    check({tag, "_hits"}, 64'(hit_count), 64'(exp_hit));
    check({tag, "_misses"}, 64'(miss_count), 64'(exp_miss));
  endtask

  // Holds read_cache until doneRead, then drops it right after the next edge.
  task automatic do_read(input string tag, input logic [15:0] addr,
                         input logic [15:0] exp_data, input int exp_rd, input int exp_lat);
    int n_rd = 0;
    int lat = 0;
    logic got = 1'b0;
    logic [15:0] data = '0;
    @(negedge clk);
    address_cache = addr;
    read_cache    = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (doneRead) begin
        got  = 1'b1;
        data = dbus;
      end else begin
        if (readM) begin
          n_rd++;
          if (n_rd == 1) check({tag, "_maddr"}, 64'(address_memory), 64'({addr[15:2], 2'b00}));
        end
        lat++;
        @(negedge clk);
      end
    end
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_data"}, 64'(data), 64'(exp_data));
    check({tag, "_readM_cycles"}, 64'(n_rd), 64'(exp_rd));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1 read_cache = 1'b0;
  endtask

  // Holds write_cache until doneWrite, checks the line put on the bus, updates the model.
  task automatic do_write(input string tag, input logic [15:0] addr, input logic [15:0] data,
                          input logic [63:0] exp_line, input int exp_rd);
    int n_rd = 0;
    int n_wr = 0;
    int n_dw = 0;
    int dw_at = 0;
    logic done = 1'b0;
    @(negedge clk);
    address_cache = addr;
    wdrv          = data;
    write_cache   = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (readM) n_rd++;
      if (writeM) begin
        n_wr++;
        if (n_wr == 1) begin
          check({tag, "_line"}, mbus, exp_line);
          check({tag, "_maddr"}, 64'(address_memory), 64'({addr[15:2], 2'b00}));
        end
      end
      if (doneWrite) begin
        n_dw++;
        dw_at = n_wr;
        done  = 1'b1;
        mem[address_memory[9:2]] = mbus;
      end else begin
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1 write_cache = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1 if (doneWrite || writeM) n_dw++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_readM_cycles"}, 64'(n_rd), 64'(exp_rd));
    check({tag, "_writeM_cycles"}, 64'(n_wr), 64'd4);
    check({tag, "_doneWrite_pulses"}, 64'(n_dw), 64'd1);
    check({tag, "_doneWrite_cycle"}, 64'(dw_at), 64'd4);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'(i) * 64'h0101_0101_0101_0101;
    mem[8'h04] = 64'h1111_2222_3333_4444;  // line 0x0010
    mem[8'h08] = 64'h5555_6666_7777_8888;  // line 0x0020
    mem[8'h0C] = 64'h9999_AAAA_BBBB_CCCC;  // line 0x0030
    mem[8'h11] = 64'hAAAA_BBBB_CCCC_DDDD;  // line 0x0044
    mem[8'h14] = 64'h0123_4567_89AB_CDEF;  // line 0x0050

    reset_n       = 1'b0;
    read_cache    = 1'b0;
    write_cache   = 1'b0;
    address_cache = '0;
    wdrv          = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_readM", 64'(readM), 64'd0);
    check("rst_writeM", 64'(writeM), 64'd0);
    check("rst_doneWrite", 64'(doneWrite), 64'd0);
    check("rst_maddr", 64'(address_memory), 64'd0);
    check_counts("rst", 0, 0);
    reset_n = 1'b1;

    // Cold read miss, then a same-line hit.
    do_read("cold_rd", 16'h0010, 16'h4444, 4, 5);
    check_counts("cold_rd", 0, 1);
    do_read("hit_rd", 16'h0011, 16'h3333, 0, 0);
    check_counts("hit_rd", 1, 1);

    // Write hit goes through to memory with the merged line.
    do_write("wr_hit", 16'h0012, 16'hBEEF, 64'h1111_BEEF_3333_4444, 0);
    check_counts("wr_hit", 2, 1);
    do_read("rd_after_wr", 16'h0012, 16'hBEEF, 0, 0);
    check_counts("rd_after_wr", 3, 1);

    // LRU: 0x0020 fills way1, 0x0010 touched, 0x0030 evicts 0x0020.
    do_read("fill_20", 16'h0020, 16'h8888, 4, 5);
    do_read("touch_10", 16'h0010, 16'h4444, 0, 0);
    do_read("fill_30", 16'h0030, 16'hCCCC, 4, 5);
    do_read("keep_10", 16'h0010, 16'h4444, 0, 0);
    do_read("evicted_20", 16'h0020, 16'h8888, 4, 5);
    check_counts("lru", 5, 4);

    // Write miss: fetch, merge, write back.
    do_write("wr_miss", 16'h0044, 16'h00AA, 64'hAAAA_BBBB_CCCC_00AA, 4);
    check_counts("wr_miss", 5, 5);
    do_read("rd_44", 16'h0044, 16'h00AA, 0, 0);
    check_counts("rd_44", 6, 5);

    // Reset in the middle of a fetch.
    @(negedge clk);
    address_cache = 16'h0050;
    read_cache    = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("mid_fetch_readM", 64'(readM), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_readM", 64'(readM), 64'd0);
    check("rst_mid_maddr", 64'(address_memory), 64'd0);
    check_counts("rst_mid", 0, 0);
    read_cache = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_read("after_rst_50", 16'h0050, 16'hCDEF, 4, 5);
    check_counts("after_rst_50", 0, 1);
    do_read("after_rst_10", 16'h0010, 16'h4444, 4, 5);
    check_counts("after_rst_10", 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
